id_stage: RTL

Instruction-decode stage of the 32-bit RISC-V (RV32I) pipeline, directly downstream of the fetch stage. It consumes the fetch pipeline outputs (instruction word, PC, PC+4) and holds the 32x32 integer register file, written by writeback. It generates sign-extended immediates and control bits, detects load-use hazards, and registers everything into the ID/EX pipeline register feeding execute.

---
 rtl/id_stage.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/id_stage.sv
// RV32I instruction-decode stage: register file with writeback bypass, immediate and
// control decode, load-use hazard detection and the ID/EX pipeline register.
module id_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pipe_pc,
  input  logic [31:0] pipe_pc4,
  input  logic [31:0] pipe_data,
  input  logic        flush,
  input  logic        wb_en,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_data,
  output logic        stall,
  output logic        ex_valid,
  output logic [31:0] ex_pc,
  output logic [31:0] ex_pc4,
  output logic [31:0] ex_rs1_data,
  output logic [31:0] ex_rs2_data,
  output logic [31:0] ex_imm,
  output logic [4:0]  ex_rs1,
  output logic [4:0]  ex_rs2,
  output logic [4:0]  ex_rd,
  output logic [6:0]  ex_opcode,
  output logic [2:0]  ex_funct3,
  output logic        ex_funct7b5,
  output logic        ex_reg_write,
  output logic        ex_mem_read,
  output logic        ex_mem_write,
  output logic        ex_branch,
  output logic        ex_jal,
  output logic        ex_jalr,
  output logic        ex_alu_src
);

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;

  logic [31:0] rf_r [0:31];
  logic [6:0]  opcode_s;
  logic [4:0]  rs1_s, rs2_s;
  logic [31:0] rs1_data_s, rs2_data_s, imm_s;
  logic        valid_s, use_rs1_s, use_rs2_s, stall_s;
  logic        reg_write_s, mem_read_s, mem_write_s, branch_s, jal_s, jalr_s, alu_src_s;

  assign opcode_s = pipe_data[6:0];
  assign rs1_s    = pipe_data[19:15];
  assign rs2_s    = pipe_data[24:20];
  assign stall    = stall_s;

  // Register file write port; x0 is never stored.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) rf_r[i] <= 32'd0;
    end else if (wb_en && (wb_rd != 5'd0)) begin
      rf_r[wb_rd] <= wb_data;
    end
  end

  // Read ports with same-cycle writeback bypass; x0 always reads zero.
  always_comb begin
    rs1_data_s = 32'd0;
    rs2_data_s = 32'd0;
    if (rs1_s == 5'd0) rs1_data_s = 32'd0;
    else if (wb_en && (wb_rd == rs1_s)) rs1_data_s = wb_data;
    else rs1_data_s = rf_r[rs1_s];
    if (rs2_s == 5'd0) rs2_data_s = 32'd0;
    else if (wb_en && (wb_rd == rs2_s)) rs2_data_s = wb_data;
    else rs2_data_s = rf_r[rs2_s];
  end

  // Opcode decode: immediate format, control bits and source-register usage.
  always_comb begin
    valid_s     = 1'b1;
    imm_s       = 32'd0;
    reg_write_s = 1'b0;
    mem_read_s  = 1'b0;
    mem_write_s = 1'b0;
    branch_s    = 1'b0;
    jal_s       = 1'b0;
    jalr_s      = 1'b0;
    alu_src_s   = 1'b1;
    use_rs1_s   = 1'b0;
    use_rs2_s   = 1'b0;
    case (opcode_s)
      OP_LUI, OP_AUIPC: begin
        imm_s       = {pipe_data[31:12], 12'd0};
        reg_write_s = 1'b1;
      end
      OP_JAL: begin
        imm_s = {{11{pipe_data[31]}}, pipe_data[31], pipe_data[19:12], pipe_data[20],
                 pipe_data[30:21], 1'b0};
        reg_write_s = 1'b1;
        jal_s       = 1'b1;
      end
      OP_JALR: begin
        imm_s       = {{20{pipe_data[31]}}, pipe_data[31:20]};
        reg_write_s = 1'b1;
        jalr_s      = 1'b1;
        use_rs1_s   = 1'b1;
      end
      OP_BRANCH: begin
        imm_s = {{19{pipe_data[31]}}, pipe_data[31], pipe_data[7], pipe_data[30:25],
                 pipe_data[11:8], 1'b0};
        branch_s  = 1'b1;
        alu_src_s = 1'b0;
        use_rs1_s = 1'b1;
        use_rs2_s = 1'b1;
      end
      OP_LOAD: begin
        imm_s       = {{20{pipe_data[31]}}, pipe_data[31:20]};
        reg_write_s = 1'b1;
        mem_read_s  = 1'b1;
        use_rs1_s   = 1'b1;
      end
      OP_STORE: begin
        imm_s       = {{20{pipe_data[31]}}, pipe_data[31:25], pipe_data[11:7]};
        mem_write_s = 1'b1;
        use_rs1_s   = 1'b1;
        use_rs2_s   = 1'b1;
      end
      OP_IMM: begin
        imm_s       = {{20{pipe_data[31]}}, pipe_data[31:20]};
        reg_write_s = 1'b1;
        use_rs1_s   = 1'b1;
      end
      OP_OP: begin
        reg_write_s = 1'b1;
        alu_src_s   = 1'b0;
        use_rs1_s   = 1'b1;
        use_rs2_s   = 1'b1;
      end
      default: begin
        valid_s   = 1'b0;
        alu_src_s = 1'b0;
      end
    endcase
  end

  // Load-use hazard; reset and flush both suppress it.
  always_comb begin
    stall_s = 1'b0;
    if (!reset && !flush && ex_valid && ex_mem_read && (ex_rd != 5'd0) &&
        ((use_rs1_s && (ex_rd == rs1_s)) || (use_rs2_s && (ex_rd == rs2_s)))) begin
      stall_s = 1'b1;
    end else begin
      stall_s = 1'b0;
    end
  end

  // ID/EX pipeline register; flushed or stalled slots keep their PC but carry no control.
  always_ff @(posedge clk) begin
    if (reset) begin
      ex_valid     <= 1'b0;
      ex_pc        <= 32'd0;
      ex_pc4       <= 32'd0;
      ex_rs1_data  <= 32'd0;
      ex_rs2_data  <= 32'd0;
      ex_imm       <= 32'd0;
      ex_rs1       <= 5'd0;
      ex_rs2       <= 5'd0;
      ex_rd        <= 5'd0;
      ex_opcode    <= 7'd0;
      ex_funct3    <= 3'd0;
      ex_funct7b5  <= 1'b0;
      ex_reg_write <= 1'b0;
      ex_mem_read  <= 1'b0;
      ex_mem_write <= 1'b0;
      ex_branch    <= 1'b0;
      ex_jal       <= 1'b0;
      ex_jalr      <= 1'b0;
      ex_alu_src   <= 1'b0;
    end else begin
      ex_pc       <= pipe_pc;
      ex_pc4      <= pipe_pc4;
      ex_rs1_data <= rs1_data_s;
      ex_rs2_data <= rs2_data_s;
      ex_imm      <= imm_s;
      ex_rs1      <= rs1_s;
      ex_rs2      <= rs2_s;
      ex_rd       <= pipe_data[11:7];
      ex_opcode   <= opcode_s;
      ex_funct3   <= pipe_data[14:12];
      ex_funct7b5 <= pipe_data[30];
      if (flush || stall_s) begin
        ex_valid     <= 1'b0;
        ex_reg_write <= 1'b0;
        ex_mem_read  <= 1'b0;
        ex_mem_write <= 1'b0;
        ex_branch    <= 1'b0;
        ex_jal       <= 1'b0;
        ex_jalr      <= 1'b0;
        ex_alu_src   <= 1'b0;
      end else begin
        ex_valid     <= valid_s;
        ex_reg_write <= reg_write_s;
        ex_mem_read  <= mem_read_s;
        ex_mem_write <= mem_write_s;
        ex_branch    <= branch_s;
        ex_jal       <= jal_s;
        ex_jalr      <= jalr_s;
        ex_alu_src   <= alu_src_s;
      end
    end
  end

endmodule
